// File: rtl/cache_hit_monitor.sv
// Direct-mapped cache tag model that classifies each CPU access as hit/miss/evict
// and maintains saturating access, hit, miss and eviction counters.
module cache_hit_monitor #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned BLOCK_BYTES = 16,
  parameter int unsigned NUM_LINES   = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              access_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              clear_i,
  output logic              hit_o,
  output logic              miss_o,
  output logic              evict_o,
  output logic [CNT_W-1:0]  access_cnt_o,
  output logic [CNT_W-1:0]  hit_cnt_o,
  output logic [CNT_W-1:0]  miss_cnt_o,
  output logic [CNT_W-1:0]  evict_cnt_o
);

  localparam int unsigned OFF_W = $clog2(BLOCK_BYTES);
  localparam int unsigned IDX_W = $clog2(NUM_LINES);
  localparam int unsigned TAG_W = ADDR_W - OFF_W - IDX_W;

  logic [NUM_LINES-1:0] r_valid;
  logic [TAG_W-1:0]     r_tags [NUM_LINES];
  logic                 r_hit;
  logic                 r_miss;
  logic                 r_evict;
  logic [CNT_W-1:0]     r_acc_cnt;
  logic [CNT_W-1:0]     r_hit_cnt;
  logic [CNT_W-1:0]     r_miss_cnt;
  logic [CNT_W-1:0]     r_evict_cnt;

  logic [IDX_W-1:0]     w_idx;
  logic [TAG_W-1:0]     w_tag;
  logic                 w_take;
  logic                 w_hit;
  logic                 w_evict;
  logic                 w_unused_off;

  assign w_idx        = addr_i[OFF_W+IDX_W-1:OFF_W];
  assign w_tag        = addr_i[ADDR_W-1:OFF_W+IDX_W];
  assign w_unused_off = ^addr_i[OFF_W-1:0];
  assign w_take       = access_i && !clear_i;
  assign w_hit        = r_valid[w_idx] && (r_tags[w_idx] == w_tag);
  assign w_evict      = !w_hit && r_valid[w_idx];

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_valid     <= '0;
      r_hit       <= 1'b0;
      r_miss      <= 1'b0;
      r_evict     <= 1'b0;
      r_acc_cnt   <= '0;
      r_hit_cnt   <= '0;
      r_miss_cnt  <= '0;
      r_evict_cnt <= '0;
    end else if (clear_i) begin
      r_valid     <= '0;
      r_hit       <= 1'b0;
      r_miss      <= 1'b0;
      r_evict     <= 1'b0;
      r_acc_cnt   <= '0;
      r_hit_cnt   <= '0;
      r_miss_cnt  <= '0;
      r_evict_cnt <= '0;
    end else begin
      r_hit   <= w_take && w_hit;
      r_miss  <= w_take && !w_hit;
      r_evict <= w_take && w_evict;
      if (w_take) begin
        r_acc_cnt <= sat_inc(r_acc_cnt);
        if (w_hit) begin
          r_hit_cnt <= sat_inc(r_hit_cnt);
        end else begin
          r_miss_cnt     <= sat_inc(r_miss_cnt);
          r_valid[w_idx] <= 1'b1;
        end
        if (w_evict) begin
          r_evict_cnt <= sat_inc(r_evict_cnt);
        end
      end
    end
  end

  // Tag RAM needs no reset: a line's tag is only consulted once its valid bit is set.
  always_ff @(posedge clk_i) begin
    if (w_take && !w_hit) begin
      r_tags[w_idx] <= w_tag;
    end
  end

  assign hit_o        = r_hit;
  assign miss_o       = r_miss;
  assign evict_o      = r_evict;
  assign access_cnt_o = r_acc_cnt;
  assign hit_cnt_o    = r_hit_cnt;
  assign miss_cnt_o   = r_miss_cnt;
  assign evict_cnt_o  = r_evict_cnt;

endmodule

// File: tb/tb_cache_hit_monitor.sv
// Directed bench for cache_hit_monitor: scoreboarded default instance plus a
// CNT_W=4 instance for counter saturation, with asynchronous reset checks.
module tb_cache_hit_monitor;

  logic        clk;
  logic        rst_n;
  logic        acc, clr;
  logic [31:0] addr;
  logic        hit, miss, evict;
  logic [31:0] acc_cnt, hit_cnt, miss_cnt, evict_cnt;

  logic        acc2, clr2;
  logic [31:0] addr2;
  logic        hit2, miss2, evict2;
  logic [3:0]  acc_cnt2, hit_cnt2, miss_cnt2, evict_cnt2;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        hit, miss, evict;
    logic [31:0] acc, hc, mc, ec;
  } exp_t;
  exp_t sbq[$];

  bit          mv [16];
  logic [23:0] mt [16];
  logic [31:0] m_acc, m_hc, m_mc, m_ec;

  cache_hit_monitor dut (
    .clk_i(clk), .rst_i(rst_n), .access_i(acc), .addr_i(addr), .clear_i(clr),
    .hit_o(hit), .miss_o(miss), .evict_o(evict),
    .access_cnt_o(acc_cnt), .hit_cnt_o(hit_cnt), .miss_cnt_o(miss_cnt), .evict_cnt_o(evict_cnt)
  );

  cache_hit_monitor #(.CNT_W(4)) dut_sat (
    .clk_i(clk), .rst_i(rst_n), .access_i(acc2), .addr_i(addr2), .clear_i(clr2),
    .hit_o(hit2), .miss_o(miss2), .evict_o(evict2),
    .access_cnt_o(acc_cnt2), .hit_cnt_o(hit_cnt2), .miss_cnt_o(miss_cnt2), .evict_cnt_o(evict_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sat32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mv[i] = 1'b0;
    m_acc = '0; m_hc = '0; m_mc = '0; m_ec = '0;
  endtask

  task automatic step(input logic a_en, input logic [31:0] a, input logic c, input string tag);
    exp_t e;
    exp_t got;
    int   idx;
    logic h;
    @(negedge clk);
    acc = a_en; addr = a; clr = c;
    e.hit = 1'b0; e.miss = 1'b0; e.evict = 1'b0;
    if (c) begin
      model_reset();
    end else if (a_en) begin
      idx     = int'(a[7:4]);
      h       = mv[idx] && (mt[idx] == a[31:8]);
      e.hit   = h;
      e.miss  = !h;
      e.evict = !h && mv[idx];
      m_acc   = sat32(m_acc);
      if (h) m_hc = sat32(m_hc);
      else   m_mc = sat32(m_mc);
      if (e.evict) m_ec = sat32(m_ec);
      if (!h) begin
        mv[idx] = 1'b1;
        mt[idx] = a[31:8];
      end
    end
    e.acc = m_acc; e.hc = m_hc; e.mc = m_mc; e.ec = m_ec;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    got = sbq.pop_front();
    chk({tag, ".hit"},   {31'd0, hit},   {31'd0, got.hit});
    chk({tag, ".miss"},  {31'd0, miss},  {31'd0, got.miss});
    chk({tag, ".evict"}, {31'd0, evict}, {31'd0, got.evict});
    chk({tag, ".acc"},   acc_cnt,   got.acc);
    chk({tag, ".hitc"},  hit_cnt,   got.hc);
    chk({tag, ".missc"}, miss_cnt,  got.mc);
    chk({tag, ".evc"},   evict_cnt, got.ec);
  endtask

  initial begin
    acc = 0; clr = 0; addr = '0;
    acc2 = 0; clr2 = 0; addr2 = '0;
    model_reset();
    rst_n = 1'b0;
    #3;
    chk("rst.pulses", {29'd0, hit, miss, evict}, 32'd0);
    chk("rst.acc", acc_cnt, 32'd0);
    chk("rst.missc", miss_cnt, 32'd0);
    chk("rst.sat_acc", {28'd0, acc_cnt2}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Compulsory miss
    step(1, 32'h0000_0000, 0, "t1");
    chk("t1.miss_k", {31'd0, miss}, 32'd1);
    chk("t1.acc_k", acc_cnt, 32'd1);

    // Same 16B line hits
    step(1, 32'h0000_0004, 0, "t2a");
    step(1, 32'h0000_000C, 0, "t2b");
    chk("t2.hitc_k", hit_cnt, 32'd2);
    chk("t2.acc_k", acc_cnt, 32'd3);

    // Conflict on index 0
    step(1, 32'h0000_0100, 0, "t3a");
    chk("t3a.evict_k", {31'd0, evict}, 32'd1);
    chk("t3a.evc_k", evict_cnt, 32'd1);
    step(1, 32'h0000_0000, 0, "t3b");
    chk("t3b.evc_k", evict_cnt, 32'd2);
    step(0, 32'h0000_0000, 0, "idle");

    // Clear with coincident access is discarded
    step(1, 32'h0000_0000, 1, "t5clr");
    chk("t5.acc_k", acc_cnt, 32'd0);
    step(1, 32'h0000_0000, 0, "t5a");
    chk("t5.miss_k", {31'd0, miss}, 32'd1);
    step(0, 32'h0000_0000, 1, "t4clr");

    // Fill all lines, then re-walk
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 16; i++)
        step(1, 32'(i) << 4, 0, "t4");
    chk("t4.acc_k", acc_cnt, 32'd32);
    chk("t4.hitc_k", hit_cnt, 32'd16);
    chk("t4.missc_k", miss_cnt, 32'd16);
    chk("t4.evc_k", evict_cnt, 32'd0);

    // Saturation on the 4-bit instance: one miss then 20 hits
    for (int i = 0; i <= 20; i++) begin
      @(negedge clk);
      acc2 = 1; addr2 = 32'h0000_0040;
      @(posedge clk);
      #1;
      chk("t6.hit", {31'd0, hit2}, (i == 0) ? 32'd0 : 32'd1);
      chk("t6.acc", {28'd0, acc_cnt2}, (i + 1 > 15) ? 32'd15 : 32'(i + 1));
      chk("t6.hitc", {28'd0, hit_cnt2}, (i > 15) ? 32'd15 : 32'(i));
      chk("t6.missc", {28'd0, miss_cnt2}, 32'd1);
    end

    // Asynchronous reset mid-stream
    @(negedge clk);
    acc = 1; addr = 32'h0000_0010; acc2 = 1;
    @(posedge clk);
    #1;
    chk("t6r.pre_hit", {31'd0, hit}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6r.pulses", {29'd0, hit, miss, evict}, 32'd0);
    chk("t6r.cnts", acc_cnt | hit_cnt | miss_cnt | evict_cnt, 32'd0);
    chk("t6r.sat_pulses", {29'd0, hit2, miss2, evict2}, 32'd0);
    chk("t6r.sat_cnts", {28'd0, acc_cnt2 | hit_cnt2 | miss_cnt2 | evict_cnt2}, 32'd0);
    @(negedge clk);
    acc = 0; acc2 = 0;
    rst_n = 1'b1;
    model_reset();
    step(1, 32'h0000_0010, 0, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
